// File: rtl/adder_sequencer.sv
// Switch-adder sequencer: synchronises and debounces START, latches A/B on each clean press,
// shows the 4-bit sum on the LEDs for HOLD_CYCLES, then returns to the live-operand view.
module adder_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic [7:0] LED,
    output logic       BUSY,
    output logic [1:0] dbg_state_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHOW    = 2'd2
    } state_t;

    logic          start_meta_q, start_s_q;
    logic [2:0]    a_q, b_q;
    logic          db_level_q, db_level_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic          press;
    state_t        state_q, state_d;
    logic [2:0]    op_a_q, op_a_d, op_b_q, op_b_d;
    logic [3:0]    sum_q, sum_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    led_q, led_d;
    logic          busy_q, busy_d;

    // A press fires on the cycle the debounced level flips 0 -> 1; releases are silent.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        press      = 1'b0;
        if (start_s_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = start_s_q;
                press      = start_s_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    op_a_d  = a_q;
                    op_b_d  = b_q;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                sum_d   = {1'b0, op_a_q} + {1'b0, op_b_q};
                hold_d  = '0;
                state_d = SHOW;
            end
            SHOW: begin
                // A new press restarts the cycle even on the timeout cycle.
                if (press) begin
                    op_a_d  = a_q;
                    op_b_d  = b_q;
                    state_d = CAPTURE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        led_d = led_q;
        case (state_q)
            IDLE:    led_d = {2'b00, a_q, b_q};
            SHOW:    led_d = {1'b1, sum_q[3], 3'b000, sum_q[2:0]};
            default: led_d = led_q;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            start_meta_q <= 1'b0;
            start_s_q    <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            db_level_q   <= 1'b0;
            db_cnt_q     <= '0;
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            sum_q        <= '0;
            hold_q       <= '0;
            led_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            start_meta_q <= START;
            start_s_q    <= start_meta_q;
            a_q          <= A;
            b_q          <= B;
            db_level_q   <= db_level_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            sum_q        <= sum_d;
            hold_q       <= hold_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
        end
    end

    assign LED         = led_q;
    assign BUSY        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Bench for adder_sequencer: timeline model feeding an expected queue, per-cycle compare,
// plus directed scenarios with hand-computed LED/BUSY values.
module tb_adder_sequencer;

    localparam int D = 4;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] a, b;
    logic [7:0] led;
    logic       busy;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];

    adder_sequencer #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .CLK(clk), .RST(rst), .START(start), .A(a), .B(b),
        .LED(led), .BUSY(busy), .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Model: START is seen two edges late; a press is D consecutive cycles of disagreement
    // ending on a high level; BUSY spans H+1 cycles from the press; the result appears
    // after the capture cycle and the live view resumes once BUSY drops.
    initial begin
        logic       m_s1, m_s2, m_level, s, pressed, was_capture;
        int         m_run, m_busy;
        logic [5:0] m_sw;
        logic [3:0] m_res;
        logic [7:0] m_led;
        m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_busy = 0;
        m_sw = '0; m_res = '0; m_led = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_busy = 0;
                m_sw = '0; m_res = '0; m_led = '0;
            end else begin
                s = m_s2;
                m_s2 = m_s1;
                m_s1 = start;
                was_capture = (m_busy == H + 1);
                if (m_busy == 0) m_led = {2'b00, m_sw};
                else if (!was_capture) m_led = {1'b1, m_res[3], 3'b000, m_res[2:0]};
                pressed = 1'b0;
                if (s != m_level) begin
                    m_run++;
                    if (m_run == D) begin
                        m_level = s;
                        m_run = 0;
                        pressed = s;
                    end
                end else begin
                    m_run = 0;
                end
                if (pressed && !was_capture) begin
                    m_res = {1'b0, m_sw[5:3]} + {1'b0, m_sw[2:0]};
                    m_busy = H + 1;
                end else if (m_busy > 0) begin
                    m_busy--;
                end
                m_sw = {a, b};
            end
            exp_q.push_back({(m_busy > 0), m_led});
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        logic [8:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (led !== e[7:0]) begin
                errors++;
                $display("FAIL model_led t=%0t got=%b exp=%b", $time, led, e[7:0]);
            end
            checks++;
            if (busy !== e[8]) begin
                errors++;
                $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, e[8]);
            end
        end
    end

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    // Call on the negedge where START has just gone (or stays) high and is clean.
    task automatic watch(input logic [7:0] el, input logic [7:0] ei);
        cyc(D + 1);
        chk("busy_before_press", {7'b0, busy}, 8'h00);
        cyc(1);
        chk("busy_after_press", {7'b0, busy}, 8'h01);
        cyc(2);
        chk("led_result", led, el);
        start = 1'b0;
        cyc(8);
        chk("busy_last_show", {7'b0, busy}, 8'h01);
        cyc(1);
        chk("busy_dropped", {7'b0, busy}, 8'h00);
        cyc(1);
        chk("led_live", led, ei);
        cyc(D + 2);
    endtask

    task automatic do_add(input logic [2:0] av, input logic [2:0] bv,
                          input logic [7:0] el, input logic [7:0] ei);
        a = av;
        b = bv;
        cyc(2);
        start = 1'b1;
        watch(el, ei);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; a = 3'd5; b = 3'd6;

        // reset with button held: reset values, then held press accepted after D clean cycles
        repeat (3) begin
            @(negedge clk);
            chk("reset_led", led, 8'h00);
            chk("reset_busy", {7'b0, busy}, 8'h00);
        end
        rst = 1'b0;
        cyc(2);
        chk("post_reset_live", led, 8'b00101110);
        cyc(D + 3);
        chk("held_press_result", led, 8'b11000011);
        start = 1'b0;
        cyc(20);

        // basic add and carries
        do_add(3'd3, 3'd4, 8'b10000111, 8'b00011100);
        do_add(3'd7, 3'd7, 8'b11000110, 8'b00111111);
        do_add(3'd7, 3'd1, 8'b11000000, 8'b00111001);

        // bounce: 2-cycle pulses then stable high -> one press
        a = 3'd1; b = 3'd1;
        cyc(2);
        start = 1'b1; cyc(2); start = 1'b0; cyc(2);
        start = 1'b1; cyc(2); start = 1'b0; cyc(2);
        start = 1'b1;
        watch(8'b10000010, 8'b00001001);

        // operand change during SHOW, then retrigger mid-SHOW
        a = 3'd2; b = 3'd3;
        cyc(2);
        start = 1'b1;
        cyc(6);
        start = 1'b0;
        a = 3'd0;
        cyc(3);
        chk("switch_change_ignored", led, 8'b10000101);
        cyc(1);
        a = 3'd1; b = 3'd2; start = 1'b1;
        cyc(7);
        chk("capture_keeps_led", led, 8'b10000101);
        cyc(1);
        chk("retrigger_result", led, 8'b10000011);
        cyc(8);
        chk("retrigger_hold_busy", {7'b0, busy}, 8'h01);
        cyc(1);
        chk("retrigger_hold_end", {7'b0, busy}, 8'h00);
        start = 1'b0;
        cyc(10);

        // reset pulse mid-SHOW
        a = 3'd2; b = 3'd2;
        cyc(2);
        start = 1'b1;
        cyc(8);
        chk("pre_reset_result", led, 8'b10000100);
        start = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midshow_reset_led", led, 8'h00);
        chk("midshow_reset_busy", {7'b0, busy}, 8'h00);
        chk("midshow_reset_state", {6'b0, dbg_state}, 8'h00);
        cyc(2);
        chk("after_reset_live", led, 8'b00010010);
        cyc(20);
        chk("no_result_reappears", led, 8'b00010010);
        chk("no_busy_reappears", {7'b0, busy}, 8'h00);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
